frame_buf_sched: RTL and testbench

//  Triple-buffer frame scheduler for the SDRAM frame store. Owns the base/max addresses and

---
 rtl/fbs_pkg.sv | 31 +++
 rtl/fbs_sync_edge.sv | 39 +++
 rtl/frame_buf_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_frame_buf_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbs_pkg.sv
// Shared types and helpers for the triple-buffer frame scheduler.
// No logic of its own; the buffer-index function is purely combinational.
// No flow control here.
package fbs_pkg;

    localparam int NUM_BUF = 3;
    localparam int IDX_W   = 2;
    localparam int CNT_W   = 4;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Lowest buffer index that is neither a nor b. With a == b this is the lowest index != a.
    function automatic idx_t third_idx(input idx_t a, input idx_t b);
        idx_t r;
        r = '0;
        for (int i = NUM_BUF - 1; i >= 0; i--) begin
            if ((idx_t'(i) != a) && (idx_t'(i) != b)) begin
                r = idx_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fbs_sync_edge.sv
// Two-flop synchroniser for an async vsync plus a registered pulse on its asserting edge.
// Latency: pulse appears 3 clock cycles after the async edge, one cycle wide.
// No backpressure: every asserting edge yields exactly one pulse.
module fbs_sync_edge
#(
    parameter bit POL = 1'b1
)
(
    input  logic sclk,
    input  logic s_rst_n,
    input  logic async_i,
    output logic edge_o
);

    localparam logic IDLE_LVL = !POL;

    logic meta_q;
    logic sync_q;
    logic dly_q;
    logic edge_q;

    // Synchronise, delay one more cycle, and flag the transition into the active level.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            meta_q <= IDLE_LVL;
            sync_q <= IDLE_LVL;
            dly_q  <= IDLE_LVL;
            edge_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
            edge_q <= (sync_q == POL) && (dly_q != POL);
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/frame_buf_sched.sv
// Triple-buffer scheduler: camera writes and TFT reads always target different buffers.
// Latency: address/load change 4 sclk cycles after an async vsync edge; load pulse LOAD_CYC wide.
// No backpressure: unread frames are dropped, missing frames repeat. Stats ports with FBS_STATS_EN.
module frame_buf_sched
    import fbs_pkg::*;
#(
    parameter int FRAME_WORDS = 384000,
    parameter int ADDR_W      = 24,
    parameter int LOAD_CYC    = 4,
    parameter bit WR_VS_POL   = 1'b1,
    parameter bit RD_VS_POL   = 1'b0
)
(
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              init_done,
    input  logic              cam_vsync,
    input  logic              tft_vs,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] wr_max_addr,
    output logic              wr_load,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_max_addr,
    output logic              rd_load,
    output logic              rd_valid
`ifdef FBS_STATS_EN
    ,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       rep_cnt
`endif
);

    localparam logic [ADDR_W-1:0] FW_A    = ADDR_W'(FRAME_WORDS);
    localparam cnt_t              LOAD_V  = cnt_t'(LOAD_CYC);
    localparam idx_t              WR_RST  = idx_t'(0);
    localparam idx_t              RD_RST  = idx_t'(2);

    function automatic logic [ADDR_W-1:0] base_of(input idx_t idx);
        return ADDR_W'(idx) * FW_A;
    endfunction

    logic wr_bnd;
    logic rd_bnd;

    fbs_sync_edge #(.POL(WR_VS_POL)) u_wr_sync (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .async_i (cam_vsync),
        .edge_o  (wr_bnd)
    );

    fbs_sync_edge #(.POL(RD_VS_POL)) u_rd_sync (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .async_i (tft_vs),
        .edge_o  (rd_bnd)
    );

    state_e            state_q,    state_d;
    idx_t              wr_idx_q,   wr_idx_d;
    idx_t              rd_idx_q,   rd_idx_d;
    idx_t              rdy_idx_q,  rdy_idx_d;
    logic              rdy_vld_q,  rdy_vld_d;
    logic              rd_valid_q, rd_valid_d;
    cnt_t              wr_cnt_q,   wr_cnt_d;
    cnt_t              rd_cnt_q,   rd_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [ADDR_W-1:0] wr_max_q,   wr_max_d;
    logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
    logic [ADDR_W-1:0] rd_max_q,   rd_max_d;
`ifdef FBS_STATS_EN
    logic [15:0]       drop_q,     drop_d;
    logic [15:0]       rep_q,      rep_d;
`endif

    // State, buffer indices, load counters and registered addresses.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q    <= ST_IDLE;
            wr_idx_q   <= WR_RST;
            rd_idx_q   <= RD_RST;
            rdy_idx_q  <= '0;
            rdy_vld_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_cnt_q   <= LOAD_V;
            rd_cnt_q   <= LOAD_V;
            wr_addr_q  <= base_of(WR_RST);
            wr_max_q   <= base_of(WR_RST) + FW_A;
            rd_addr_q  <= base_of(RD_RST);
            rd_max_q   <= base_of(RD_RST) + FW_A;
`ifdef FBS_STATS_EN
            drop_q     <= '0;
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            rdy_idx_q  <= rdy_idx_d;
            rdy_vld_q  <= rdy_vld_d;
            rd_valid_q <= rd_valid_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_addr_q  <= wr_addr_d;
            wr_max_q   <= wr_max_d;
            rd_addr_q  <= rd_addr_d;
            rd_max_q   <= rd_max_d;
`ifdef FBS_STATS_EN
            drop_q     <= drop_d;
            rep_q      <= rep_d;
`endif
        end
    end

    // Next-state: buffer rotation on vsync boundaries, load pulse timing, abort on init_done loss.
    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        rdy_idx_d  = rdy_idx_q;
        rdy_vld_d  = rdy_vld_q;
        rd_valid_d = rd_valid_q;
        wr_cnt_d   = (wr_cnt_q != '0) ? wr_cnt_q - cnt_t'(1) : '0;
        rd_cnt_d   = (rd_cnt_q != '0) ? rd_cnt_q - cnt_t'(1) : '0;
`ifdef FBS_STATS_EN
        drop_d     = drop_q;
        rep_d      = rep_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                wr_cnt_d = LOAD_V;
                rd_cnt_d = LOAD_V;
`ifdef FBS_STATS_EN
                drop_d   = '0;
                rep_d    = '0;
`endif
                if (init_done) begin
                    state_d = ST_ALIGN;
                end
            end
            // Read boundaries are ignored until the writer is aligned to a frame start.
            ST_ALIGN: begin
                if (wr_bnd) begin
                    wr_idx_d = WR_RST;
                    wr_cnt_d = LOAD_V;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_bnd) begin
                    wr_cnt_d = LOAD_V;
`ifdef FBS_STATS_EN
                    if (rdy_vld_q && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
`endif
                    if (rd_bnd) begin
                        // Reader takes the frame that just completed.
                        rd_idx_d   = wr_idx_q;
                        wr_idx_d   = third_idx(wr_idx_q, wr_idx_q);
                        rdy_vld_d  = 1'b0;
                        rd_valid_d = 1'b1;
                        rd_cnt_d   = LOAD_V;
                    end else begin
                        rdy_idx_d  = wr_idx_q;
                        rdy_vld_d  = 1'b1;
                        wr_idx_d   = third_idx(wr_idx_q, rd_idx_q);
                    end
                end else if (rd_bnd) begin
                    rd_cnt_d = LOAD_V;
                    if (rdy_vld_q) begin
                        rd_idx_d   = rdy_idx_q;
                        rdy_vld_d  = 1'b0;
                        rd_valid_d = 1'b1;
                    end else begin
`ifdef FBS_STATS_EN
                        if (rep_q != 16'hFFFF) rep_d = rep_q + 16'd1;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!init_done) begin
            state_d    = ST_IDLE;
            wr_idx_d   = WR_RST;
            rd_idx_d   = RD_RST;
            rdy_vld_d  = 1'b0;
            rd_valid_d = 1'b0;
            wr_cnt_d   = LOAD_V;
            rd_cnt_d   = LOAD_V;
`ifdef FBS_STATS_EN
            drop_d     = '0;
            rep_d      = '0;
`endif
        end

        wr_addr_d = base_of(wr_idx_d);
        wr_max_d  = base_of(wr_idx_d) + FW_A;
        rd_addr_d = base_of(rd_idx_d);
        rd_max_d  = base_of(rd_idx_d) + FW_A;
    end

    // Writer, reader and pending slot must always name three distinct buffers.
    assert property (@(posedge sclk) disable iff (!s_rst_n)
        (wr_idx_q != rd_idx_q) &&
        (!rdy_vld_q || ((rdy_idx_q != wr_idx_q) && (rdy_idx_q != rd_idx_q))));

    assign wr_addr     = wr_addr_q;
    assign wr_max_addr = wr_max_q;
    assign wr_load     = (wr_cnt_q != '0);
    assign rd_addr     = rd_addr_q;
    assign rd_max_addr = rd_max_q;
    assign rd_load     = (rd_cnt_q != '0);
    assign rd_valid    = rd_valid_q;
`ifdef FBS_STATS_EN
    assign drop_cnt    = drop_q;
    assign rep_cnt     = rep_q;
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// Bench for frame_buf_sched: directed vsync sequences with hand-computed buffer addresses.
// Expected addresses are queued at stimulus time and popped on each load-pulse rising edge.
// Stats outputs are checked when FBS_STATS_EN is defined.
module tb_frame_buf_sched;

    localparam int F = 384000;

    logic        sclk;
    logic        s_rst_n;
    logic        init_done;
    logic        cam_vsync;
    logic        tft_vs;
    logic [23:0] wr_addr;
    logic [23:0] wr_max_addr;
    logic        wr_load;
    logic [23:0] rd_addr;
    logic [23:0] rd_max_addr;
    logic        rd_load;
    logic        rd_valid;
`ifdef FBS_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] rep_cnt;
`endif

    frame_buf_sched dut (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .init_done   (init_done),
        .cam_vsync   (cam_vsync),
        .tft_vs      (tft_vs),
        .wr_addr     (wr_addr),
        .wr_max_addr (wr_max_addr),
        .wr_load     (wr_load),
        .rd_addr     (rd_addr),
        .rd_max_addr (rd_max_addr),
        .rd_load     (rd_load),
        .rd_valid    (rd_valid)
`ifdef FBS_STATS_EN
        ,
        .drop_cnt    (drop_cnt),
        .rep_cnt     (rep_cnt)
`endif
    );

    typedef struct {
        logic [23:0] addr;
        logic        vld;
    } exp_t;

    exp_t wr_q[$];
    exp_t rd_q[$];
    int   checks = 0;
    int   errors = 0;

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_ne(input string nm, input logic [31:0] a, input logic [31:0] b);
        checks++;
        if (a === b) begin
            errors++;
            $display("FAIL %s actual=%0d required!=%0d", nm, a, b);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge sclk);
        #2;
    endtask

    task automatic cam_frame(input logic [23:0] a);
        wr_q.push_back('{addr: a, vld: 1'b0});
        cam_vsync = 1'b1;
        cyc(10);
        cam_vsync = 1'b0;
        cyc(10);
    endtask

    task automatic tft_frame(input logic [23:0] a);
        rd_q.push_back('{addr: a, vld: 1'b1});
        tft_vs = 1'b0;
        cyc(10);
        tft_vs = 1'b1;
        cyc(10);
    endtask

    task automatic both_frame(input logic [23:0] wa, input logic [23:0] ra);
        wr_q.push_back('{addr: wa, vld: 1'b0});
        rd_q.push_back('{addr: ra, vld: 1'b1});
        cam_vsync = 1'b1;
        tft_vs    = 1'b0;
        cyc(10);
        cam_vsync = 1'b0;
        tft_vs    = 1'b1;
        cyc(10);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wr_load"},  32'(wr_load),  32'd1);
        chk({tag, "_rd_load"},  32'(rd_load),  32'd1);
        chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        chk({tag, "_rd_addr"},  32'(rd_addr),  32'(2 * F));
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
`ifdef FBS_STATS_EN
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
        chk({tag, "_rep_cnt"},  32'(rep_cnt),  32'd0);
`endif
    endtask

    // Write-port monitor: on each wr_load rise compare address, then measure the pulse width.
    initial begin : wr_mon
        logic prev;
        bit   inp;
        int   width;
        exp_t e;
        prev  = 1'b1;
        inp   = 1'b0;
        width = 0;
        forever begin
            @(negedge sclk);
            if (init_done && wr_load && !prev) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected_load", 32'd1, 32'd0);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_max_addr", 32'(wr_max_addr), 32'(e.addr) + 32'(F));
                end
                inp   = 1'b1;
                width = 1;
            end else if (inp && wr_load) begin
                width++;
            end else if (inp && !wr_load) begin
                chk("wr_load_width", 32'(width), 32'd4);
                inp = 1'b0;
            end
            prev = wr_load;
        end
    end

    // Read-port monitor: on each rd_load rise compare address and valid, and check no tearing.
    initial begin : rd_mon
        logic prev;
        bit   inp;
        int   width;
        exp_t e;
        prev  = 1'b1;
        inp   = 1'b0;
        width = 0;
        forever begin
            @(negedge sclk);
            if (init_done && rd_load && !prev) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected_load", 32'd1, 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(e.addr));
                    chk("rd_max_addr", 32'(rd_max_addr), 32'(e.addr) + 32'(F));
                    chk("rd_valid", 32'(rd_valid), 32'(e.vld));
                    chk_ne("rd_ne_wr", 32'(rd_addr), 32'(wr_addr));
                end
                inp   = 1'b1;
                width = 1;
            end else if (inp && rd_load) begin
                width++;
            end else if (inp && !rd_load) begin
                chk("rd_load_width", 32'(width), 32'd4);
                inp = 1'b0;
            end
            prev = rd_load;
        end
    end

    initial begin : stim
        s_rst_n   = 1'b0;
        init_done = 1'b0;
        cam_vsync = 1'b0;
        tft_vs    = 1'b1;
        @(negedge sclk);
        chk_idle("rst");
        chk("rst_wr_max", 32'(wr_max_addr), 32'(F));
        chk("rst_rd_max", 32'(rd_max_addr), 32'(3 * F));
        cyc(3);
        s_rst_n = 1'b1;

        // Idle with vsyncs toggling: loads stay high, indices stay at reset.
        for (int i = 0; i < 4; i++) begin
            cam_vsync = ~cam_vsync;
            tft_vs    = ~tft_vs;
            cyc(6);
            @(negedge sclk);
            chk_idle("idle");
        end
        cyc(6);

        // Leaving IDLE lets both loads fall.
        init_done = 1'b1;
        cyc(8);
        @(negedge sclk);
        chk("align_wr_load", 32'(wr_load), 32'd0);
        chk("align_rd_load", 32'(rd_load), 32'd0);
        cyc(1);

        // Alignment, first completed frame, first display.
        cam_frame(24'd0);
        cam_frame(24'(F));
        @(negedge sclk);
        chk("pre_display_rd_valid", 32'(rd_valid), 32'd0);
        cyc(1);
        tft_frame(24'd0);

        // Two camera frames per display frame: one drop each time.
        cam_frame(24'(2 * F));
        cam_frame(24'(F));
        tft_frame(24'(2 * F));
        cam_frame(24'd0);
        cam_frame(24'(F));
        tft_frame(24'd0);
`ifdef FBS_STATS_EN
        @(negedge sclk);
        chk("drop_cnt_fast_cam", 32'(drop_cnt), 32'd2);
        chk("rep_cnt_fast_cam",  32'(rep_cnt),  32'd0);
        cyc(1);
`endif

        // Two display frames per camera frame: repeats.
        tft_frame(24'd0);
        tft_frame(24'd0);
`ifdef FBS_STATS_EN
        @(negedge sclk);
        chk("rep_cnt_fast_tft", 32'(rep_cnt), 32'd2);
        cyc(1);
`endif
        cam_frame(24'(2 * F));
        tft_frame(24'(F));
        cam_frame(24'd0);
        tft_frame(24'(2 * F));
        cam_frame(24'(F));
        tft_frame(24'd0);

        // Coincident boundaries with wr=1, rd=0; the following display frame must repeat.
        both_frame(24'd0, 24'(F));
        tft_frame(24'(F));
`ifdef FBS_STATS_EN
        @(negedge sclk);
        chk("drop_cnt_same_cycle", 32'(drop_cnt), 32'd2);
        chk("rep_cnt_same_cycle",  32'(rep_cnt),  32'd3);
        cyc(1);
`endif

        // Mid-frame abort.
        wr_q.push_back('{addr: 24'(2 * F), vld: 1'b0});
        cam_vsync = 1'b1;
        cyc(10);
        init_done = 1'b0;
        @(posedge sclk);
        @(negedge sclk);
        chk_idle("abort");
        cyc(1);
        cam_vsync = 1'b0;
        cyc(6);

        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
